// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: packs up to four per-cycle commit events (reg writes and stores)
// into a FIFO with all-or-nothing admission, and emits them one per handshake.
module commit_trace_serializer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       reg_we,
    input  logic [1:0][4:0]  reg_waddr,
    input  logic [1:0][31:0] reg_wdata,
    input  logic [1:0]       st_valid,
    input  logic [1:0][15:0] st_addr,
    input  logic [1:0][31:0] st_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_kind,
    output logic [15:0]      ev_addr,
    output logic [31:0]      ev_data,
    output logic [31:0]      ev_cycle,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic        kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] cycle;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          cand [4];
    entry_t          head;
    logic [2:0]      n_cand;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]   occupancy, free_space;
    logic [31:0]     cycle_q;
    logic            overflow_q;
    logic [15:0]     drop_q;
    logic            full, push, drop, pop;

    // Gather candidates in commit order, packed without gaps.
    always_comb begin
        n_cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            if (reg_we[s] && (reg_waddr[s] != 5'd0)) begin
                cand[n_cand[1:0]] = '{kind: 1'b0, addr: {11'b0, reg_waddr[s]},
                                      data: reg_wdata[s], cycle: cycle_q};
                n_cand = n_cand + 3'd1;
            end
            if (st_valid[s]) begin
                cand[n_cand[1:0]] = '{kind: 1'b1, addr: st_addr[s],
                                      data: st_data[s], cycle: cycle_q};
                n_cand = n_cand + 3'd1;
            end
        end
    end

    // Room is judged before this cycle's pop, so a pop never admits a push.
    always_comb begin
        full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        occupancy  = wptr_q - rptr_q;
        free_space = full ? '0 : (PW'(DEPTH) - occupancy);
        drop       = PW'(n_cand) > free_space;
        push       = (n_cand != 3'd0) && !drop;
        ev_valid   = (wptr_q != rptr_q);
        pop        = ev_valid && ev_ready;
        wptr_d     = wptr_q + (push ? PW'(n_cand) : '0);
        rptr_d     = rptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push && (3'(i) < n_cand)) begin
                mem[AW'(wptr_q[AW-1:0] + AW'(i))] <= cand[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cycle_q <= cycle_q + 32'd1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        head     = mem[rptr_q[AW-1:0]];
        ev_kind  = head.kind;
        ev_addr  = head.addr;
        ev_data  = head.data;
        ev_cycle = head.cycle;
        overflow = overflow_q;
        drop_cnt = drop_q;
    end

endmodule

// File: doc/commit_trace_serializer.md
COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entry count; SHALL be a power of two, >= 4.
REQ-002 clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 reg_we  input  2  per-commit-slot register write enable (slot 0 older than slot 1).
REQ-005 reg_waddr  input  2x5  per-slot destination register number.
REQ-006 reg_wdata  input  2x32  per-slot register write data.
REQ-007 st_valid  input  2  per-slot committed store push.
REQ-008 st_addr  input  2x16  per-slot store physical address, low 16 bits.
REQ-009 st_data  input  2x32  per-slot store write data.
REQ-010 ev_valid  output  1  trace event available.
REQ-011 ev_ready  input  1  consumer accepts the event.
REQ-012 ev_kind  output  1  0 = register write, 1 = store.
REQ-013 ev_addr  output  16  register number (zero-extended) or store address.
REQ-014 ev_data  output  32  written value.
REQ-015 ev_cycle  output  32  cycle stamp of the commit cycle.
REQ-016 overflow  output  1  sticky: at least one commit cycle was dropped.
REQ-017 drop_cnt  output  16  number of dropped commit cycles, saturating.

Function
REQ-018 Per cycle, candidate events SHALL be collected in fixed order: slot0 reg, slot0 store, slot1 reg, slot1 store.
REQ-019 Register writes with reg_waddr == 0 SHALL be discarded and not counted as candidates.
REQ-020 Candidate count N (0..4) SHALL be pushed into the FIFO in the REQ-018 order in the same cycle, packed contiguously, without gaps.
REQ-021 A free-running 32-bit cycle counter SHALL increment every cycle after reset, wrap 0xFFFFFFFF -> 0, and stamp all events of that cycle with its current value.
REQ-022 Free space SHALL be computed from occupancy before the same-cycle pop; a pop in the same cycle SHALL NOT create room for a push.
REQ-023 If N > free space, all N events of that cycle SHALL be dropped (no partial push), overflow SHALL set, drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-024 overflow SHALL remain 1 until reset.
REQ-025 ev_valid SHALL equal FIFO non-empty; ev_kind/addr/data/cycle SHALL reflect the head entry combinationally from storage.
REQ-026 A pop SHALL occur when ev_valid && ev_ready; ev_ready while empty SHALL have no effect.
REQ-027 While ev_valid && !ev_ready, head outputs SHALL remain stable.
REQ-028 Push latency: an event committed in cycle T SHALL be visible at head no earlier than cycle T+1 (registered write, no bypass).
REQ-029 Read/write pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full = equal index, differing wrap bit; empty = equal pointers.
REQ-030 Simultaneous push of N and pop of 1 SHALL update occupancy by N-1.
REQ-031 Output event order SHALL equal commit order across cycles and across slots.

Reset
REQ-032 On rst_n low, asynchronously: pointers 0, cycle counter 0, overflow 0, drop_cnt 0, ev_valid 0; FIFO contents need not be cleared.
REQ-033 Reset asserted mid-burst SHALL discard all queued events; the first cycle after release SHALL stamp cycle 0.

Verification
REQ-034 Slot0 reg $3=0x12345678, slot1 store [0x0100]=0xdeadbeef in cycle 5, ev_ready=1 -> events (0,3,0x12345678,5) then (1,0x0100,0xdeadbeef,5) on consecutive cycles.
REQ-035 reg_we=2'b11, waddr {0,7} -> only $7 emitted; $0 never appears.
REQ-036 DEPTH=16, ev_ready=0, four events per cycle for 4 cycles -> full, ev_valid=1, no drop; fifth cycle with 1 event -> overflow=1, drop_cnt=1, occupancy 16.
REQ-037 FIFO holding 14, ev_ready=1, 3 candidates -> dropped per REQ-022 (free 2 < 3), drop_cnt increments, one pop occurs.
REQ-038 ev_ready toggled pseudo-randomly over 1000 random commits -> output stream equals scoreboard order exactly, outputs stable while stalled.
REQ-039 rst_n pulled low with 10 events queued -> ev_valid=0 immediately, overflow=0, drop_cnt=0; after release stamps restart at 0.
